// File: rtl/console_palette.sv
// console_palette: text-console colour stage.
// Converts an 8-bit character attribute and a font pixel bit into one RGB pixel.
// The stage has a 16-entry runtime palette, an internal blink generator and a
// two-cycle valid-tracked pipeline.
// Optional feature macro: CONSOLE_BRIGHT_BG_EN. When defined, attribute[7] is a
// background-intensity bit and blinking is never applied.
module console_palette #(
  parameter int unsigned BIT_WIDTH    = 8,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pal_wr_en,
  input  logic [3:0]             pal_wr_index,
  input  logic [3*BIT_WIDTH-1:0] pal_wr_rgb,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [7:0]             attribute,
  input  logic                   glyph_pixel,
  output logic                   out_valid,
  output logic [3*BIT_WIDTH-1:0] rgb,
  output logic                   blink_phase
);

  localparam int unsigned RGB_W = 3 * BIT_WIDTH;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
`ifdef CONSOLE_BRIGHT_BG_EN
  localparam bit BLINK_EN = 1'b0;
`else
  localparam bit BLINK_EN = 1'b1;
`endif

  // VGA default colour for a palette index, each channel cut to its top BIT_WIDTH bits
  function automatic logic [RGB_W-1:0] vga_default(input logic [3:0] idx);
    logic [23:0] c;
    logic [7:0]  r, g, b;
    case (idx)
      4'd0:    c = 24'h000000;
      4'd1:    c = 24'h0000AA;
      4'd2:    c = 24'h00AA00;
      4'd3:    c = 24'h00AAAA;
      4'd4:    c = 24'hAA0000;
      4'd5:    c = 24'hAA00AA;
      4'd6:    c = 24'hAA5500;
      4'd7:    c = 24'hAAAAAA;
      4'd8:    c = 24'h555555;
      4'd9:    c = 24'h5555FF;
      4'd10:   c = 24'h55FF55;
      4'd11:   c = 24'h55FFFF;
      4'd12:   c = 24'hFF5555;
      4'd13:   c = 24'hFF55FF;
      4'd14:   c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
    return {r[7 -: BIT_WIDTH], g[7 -: BIT_WIDTH], b[7 -: BIT_WIDTH]};
  endfunction

  logic [RGB_W-1:0] pal_q [16];
  logic [RGB_W-1:0] pal_d [16];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic             s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0] s1_fg_q, s1_fg_d;
  logic [RGB_W-1:0] s1_bg_q, s1_bg_d;
  logic             s1_glyph_q, s1_glyph_d;
  logic             s1_blink_q, s1_blink_d;
  logic             s1_phase_q, s1_phase_d;

  logic             out_valid_q, out_valid_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic [3:0]       bg_idx;
  logic             hide;

  // Palette write port; lookups this cycle still see the pre-write contents
  always_comb begin
    pal_d = pal_q;
    if (pal_wr_en) pal_d[pal_wr_index] = pal_wr_rgb;
  end

  // Blink generator: advance on each frame_start, toggle phase on wrap
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: capture looked-up colours and blink context of a valid pixel
  always_comb begin
`ifdef CONSOLE_BRIGHT_BG_EN
    bg_idx = attribute[7:4];
`else
    bg_idx = {1'b0, attribute[6:4]};
`endif
    s1_valid_d = in_valid;
    s1_fg_d    = s1_fg_q;
    s1_bg_d    = s1_bg_q;
    s1_glyph_d = s1_glyph_q;
    s1_blink_d = s1_blink_q;
    s1_phase_d = s1_phase_q;
    if (in_valid) begin
      s1_fg_d    = pal_q[attribute[3:0]];
      s1_bg_d    = pal_q[bg_idx];
      s1_glyph_d = glyph_pixel;
      s1_blink_d = attribute[7];
      s1_phase_d = phase_q;
    end
  end

  // Stage 2: pick foreground or background; hold colour across bubbles
  always_comb begin
    hide        = BLINK_EN && s1_blink_q && s1_phase_q;
    out_valid_d = s1_valid_q;
    rgb_d       = rgb_q;
    if (s1_valid_q) rgb_d = (s1_glyph_q && !hide) ? s1_fg_q : s1_bg_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) pal_q[i] <= vga_default(4'(i));
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      s1_glyph_q  <= 1'b0;
      s1_blink_q  <= 1'b0;
      s1_phase_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      pal_q       <= pal_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_fg_q     <= s1_fg_d;
      s1_bg_q     <= s1_bg_d;
      s1_glyph_q  <= s1_glyph_d;
      s1_blink_q  <= s1_blink_d;
      s1_phase_q  <= s1_phase_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign rgb         = rgb_q;
  assign blink_phase = phase_q;

endmodule
